gpio_irq: RTL

- Interrupt and glitch-filter stage directly downstream of the GPIO block's synchronised input path.
- Consumes the 32 double-flopped pin values and filters each pin for stability.
- Detects per-pin edge or level events, holds pending status, and drives the 4 grouped interrupt lines into the CPU.
- Uses the same 3-bit-address, byte-enable register interface as the GPIO block, so it sits on the same peripheral bus.

---
 rtl/gpio_pkg.sv | 36 +++
 rtl/gpio_irq_if.sv | 32 +++
 rtl/gpio_irq_filter.sv | 53 +++++
 rtl/gpio_irq.sv | 123 ++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// ----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO block and its interrupt stage.
//   - Register address constants for both decode windows. The gpio_irq
//     addresses are local to that block's own 3-bit window.
//   - Interrupt grouping: IRQ_GROUPS lines, each covering IRQ_GROUP_W pins.
//   - byte_mask(): expands the 4 per-byte write strobes to a 32-bit bit mask.
// ----------------------------------------------------------------------------
package gpio_pkg;

    localparam int GPIO_W = 32;

    // GPIO block register window
    localparam logic [2:0] GPIO_MODE_REG   = 3'd0;
    localparam logic [2:0] GPIO_DATA_REG   = 3'd1;

    // gpio_irq register window
    localparam logic [2:0] IRQ_ENABLE_REG  = 3'd0;
    localparam logic [2:0] IRQ_EDGE_REG    = 3'd1;
    localparam logic [2:0] IRQ_POL_REG     = 3'd2;
    localparam logic [2:0] IRQ_PENDING_REG = 3'd3;
    localparam logic [2:0] IRQ_FILT_REG    = 3'd4;
    localparam logic [2:0] IRQ_SET_REG     = 3'd5;

    localparam int IRQ_GROUPS  = 4;
    localparam int IRQ_GROUP_W = 8;

    function automatic logic [GPIO_W-1:0] byte_mask(input logic [3:0] wr_en);
        logic [GPIO_W-1:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{wr_en[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// ----------------------------------------------------------------------------
// gpio_irq_if
// Peripheral register bus shared with the GPIO block.
//   i_addr  : 3-bit register select
//   i_din   : 32-bit write data
//   i_wr_en : per-byte write strobes, bit k covers i_din[8k+7:8k]
//   o_dout  : combinational read data for i_addr
// The master modport is the bus side; the slave modport is the register block.
// ----------------------------------------------------------------------------
interface gpio_irq_if;
    import gpio_pkg::*;

    logic [2:0]        i_addr;
    logic [GPIO_W-1:0] i_din;
    logic [3:0]        i_wr_en;
    logic [GPIO_W-1:0] o_dout;

    modport master (
        output i_addr,
        output i_din,
        output i_wr_en,
        input  o_dout
    );

    modport slave (
        input  i_addr,
        input  i_din,
        input  i_wr_en,
        output o_dout
    );

endinterface

// File: rtl/gpio_irq_filter.sv
// ----------------------------------------------------------------------------
// gpio_irq_filter
// Single-pin stability filter.
//   i_clk, i_rstb : clock and asynchronous active-low reset
//   i_pin         : synchronised pin value, sampled every clock
//   o_filt_q      : current filtered value
//   o_filt_d      : next filtered value (lets the parent see a transition
//                   in the same cycle that o_filt_q will update)
// The filtered value only moves once FILTER_DEPTH consecutive samples agree,
// so pulses shorter than FILTER_DEPTH clocks are swallowed.
// ----------------------------------------------------------------------------
module gpio_irq_filter #(
    parameter int FILTER_DEPTH = 3
) (
    input  logic i_clk,
    input  logic i_rstb,
    input  logic i_pin,
    output logic o_filt_q,
    output logic o_filt_d
);

    logic [FILTER_DEPTH-1:0] sh_q;
    logic [FILTER_DEPTH-1:0] sh_d;
    logic                    filt_q;
    logic                    filt_d;

    // sh_q[0] is the newest sample. Shifting left with an OR-ed sized cast
    // works for every depth, including a 1-bit register.
    always_comb begin
        sh_d = (sh_q << 1) | (FILTER_DEPTH)'(i_pin);

        filt_d = filt_q;
        if (&sh_q) begin
            filt_d = 1'b1;
        end else if (~|sh_q) begin
            filt_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            sh_q   <= '0;
            filt_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            filt_q <= filt_d;
        end
    end

    assign o_filt_q = filt_q;
    assign o_filt_d = filt_d;

endmodule

// File: rtl/gpio_irq.sv
// ----------------------------------------------------------------------------
// gpio_irq
// Glitch filter, event detection and grouped interrupts for 32 GPIO pins.
//   i_clk, i_rstb : clock and asynchronous active-low reset
//   bus           : register bus (slave side)
//                     0 ENABLE  RW     per-pin interrupt enable
//                     1 EDGE    RW     1 = edge mode, 0 = level mode
//                     2 POL     RW     1 = rising/high, 0 = falling/low
//                     3 PENDING RW1C   edge: latched events, level: live state
//                     4 FILT    RO     filtered pin values
//                     5 SET     W1S    sets pending bits, reads 0
//                     6-7              read 0, writes ignored
//   i_gpio_sync   : pins already double-flopped by the GPIO block
//   o_irq         : o_irq[k] = OR of enabled pending bits 8k..8k+7
// ----------------------------------------------------------------------------
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int FILTER_DEPTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rstb,
    gpio_irq_if.slave             bus,
    input  logic [GPIO_W-1:0]     i_gpio_sync,
    output logic [IRQ_GROUPS-1:0] o_irq
);

    logic [GPIO_W-1:0] enable_q,  enable_d;
    logic [GPIO_W-1:0] edge_en_q, edge_en_d;
    logic [GPIO_W-1:0] pol_q,     pol_d;
    logic [GPIO_W-1:0] pend_q,    pend_d;

    logic [GPIO_W-1:0] filt_q;
    logic [GPIO_W-1:0] filt_d;

    logic [GPIO_W-1:0] wmask;
    logic [GPIO_W-1:0] w1c;
    logic [GPIO_W-1:0] w1s;
    logic [GPIO_W-1:0] rise;
    logic [GPIO_W-1:0] fall;
    logic [GPIO_W-1:0] evt;
    logic [GPIO_W-1:0] pend_eff;
    logic [GPIO_W-1:0] irq_src;

    for (genvar i = 0; i < GPIO_W; i++) begin : g_filt
        gpio_irq_filter #(
            .FILTER_DEPTH (FILTER_DEPTH)
        ) u_filt (
            .i_clk    (i_clk),
            .i_rstb   (i_rstb),
            .i_pin    (i_gpio_sync[i]),
            .o_filt_q (filt_q[i]),
            .o_filt_d (filt_d[i])
        );
    end

    // Register writes, W1C/W1S decode and pending update.
    always_comb begin
        wmask = byte_mask(bus.i_wr_en);

        enable_d  = enable_q;
        edge_en_d = edge_en_q;
        pol_d     = pol_q;
        w1c       = '0;
        w1s       = '0;

        case (bus.i_addr)
            IRQ_ENABLE_REG:  enable_d  = (enable_q  & ~wmask) | (bus.i_din & wmask);
            IRQ_EDGE_REG:    edge_en_d = (edge_en_q & ~wmask) | (bus.i_din & wmask);
            IRQ_POL_REG:     pol_d     = (pol_q     & ~wmask) | (bus.i_din & wmask);
            IRQ_PENDING_REG: w1c       = bus.i_din & wmask;
            IRQ_SET_REG:     w1s       = bus.i_din & wmask;
            default: ;
        endcase

        // Events come only from filter transitions, never from EDGE/POL writes.
        rise = filt_d & ~filt_q;
        fall = ~filt_d & filt_q;
        evt  = edge_en_q & ((pol_q & rise) | (~pol_q & fall));

        // The event term is OR-ed after the clear so a coincident event wins.
        // Level-mode bits store nothing, so a later switch to edge mode
        // always starts with a clear pending bit.
        pend_d = edge_en_q & ((pend_q & ~w1c) | w1s | evt);

        // Level-mode pending is the live comparison of the pin with POL.
        pend_eff = (edge_en_q & pend_q) | (~edge_en_q & ~(filt_q ^ pol_q));
        irq_src  = pend_eff & enable_q;
    end

    always_comb begin
        o_irq = '0;
        for (int k = 0; k < IRQ_GROUPS; k++) begin
            o_irq[k] = |irq_src[k*IRQ_GROUP_W +: IRQ_GROUP_W];
        end
    end

    always_comb begin
        case (bus.i_addr)
            IRQ_ENABLE_REG:  bus.o_dout = enable_q;
            IRQ_EDGE_REG:    bus.o_dout = edge_en_q;
            IRQ_POL_REG:     bus.o_dout = pol_q;
            IRQ_PENDING_REG: bus.o_dout = pend_eff;
            IRQ_FILT_REG:    bus.o_dout = filt_q;
            default:         bus.o_dout = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            enable_q  <= '0;
            edge_en_q <= '0;
            pol_q     <= '0;
            pend_q    <= '0;
        end else begin
            enable_q  <= enable_d;
            edge_en_q <= edge_en_d;
            pol_q     <= pol_d;
            pend_q    <= pend_d;
        end
    end

endmodule
